// File: rtl/wb_commit_arbiter.sv
// rtl/wb_commit_arbiter.sv - register file write arbiter merging ALU and buffered results, with busy scoreboard
// Optional same-cycle mem bypass into an empty FIFO is enabled by defining WB_BYPASS_EN.
module wb_commit_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [4:0]                 mem_rd,
    input  logic [31:0]                mem_data,
    input  logic                       issue_valid,
    input  logic [4:0]                 issue_rd,
    output logic [31:0]                busy,
    output logic [4:0]                 rd_addr,
    output logic                       reg_write,
    output logic [31:0]                wr_data,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_rd   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic        fifo_empty;
    logic        starve_stall;
    logic        grant_alu;
    logic        grant_fifo;
    logic        grant_byp;
    logic        any_grant;
    logic        enq;
    logic        deq;
    logic [4:0]  grant_rd;
    logic [31:0] grant_data;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] busy_next;

    assign fifo_empty   = (count == '0);
    assign starve_stall = (starve_cnt == SW'(STARVE_LIMIT)) && !fifo_empty;
    assign alu_ready    = !starve_stall;
    // Credit comes only from registered occupancy; a same-cycle dequeue does not free a slot.
    assign mem_ready    = (count != CW'(DEPTH));
    assign grant_alu    = alu_valid && !starve_stall;
    assign grant_fifo   = !fifo_empty && (starve_stall || !alu_valid);
`ifdef WB_BYPASS_EN
    assign grant_byp    = fifo_empty && !alu_valid && mem_valid;
`else
    assign grant_byp    = 1'b0;
`endif
    assign any_grant    = grant_alu || grant_fifo || grant_byp;
    assign enq          = mem_valid && mem_ready && !grant_byp;
    assign deq          = grant_fifo;
    assign fifo_count   = count;

    always_comb begin
        grant_rd   = alu_rd;
        grant_data = alu_data;
        if (grant_fifo) begin
            grant_rd   = fifo_rd[rd_ptr];
            grant_data = fifo_data[rd_ptr];
        end else if (grant_byp) begin
            grant_rd   = mem_rd;
            grant_data = mem_data;
        end
    end

    // Set wins over clear on the same register; x0 is never tracked.
    always_comb begin
        set_mask  = issue_valid ? (32'd1 << issue_rd) : 32'd0;
        clr_mask  = (grant_fifo || grant_byp) ? (32'd1 << grant_rd) : 32'd0;
        busy_next = ((busy & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[wr_ptr]   <= mem_rd;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            busy       <= '0;
            rd_addr    <= '0;
            reg_write  <= 1'b0;
            wr_data    <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (fifo_empty || grant_fifo) begin
                starve_cnt <= '0;
            end else if (grant_alu && starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            busy <= busy_next;

            // Beats to x0 are consumed without a write; address/data keep their last values.
            if (any_grant && grant_rd != 5'd0) begin
                rd_addr   <= grant_rd;
                wr_data   <= grant_data;
                reg_write <= 1'b1;
            end else begin
                reg_write <= 1'b0;
            end
        end
    end
endmodule

// File: doc/wb_commit_arbiter.md
Name: wb_commit_arbiter

Overview:
- Writer side of the core register file: the only block that drives rd_addr, reg_write and wr_data.
- Merges two result sources into one registered write port:
  - the single-cycle ALU path;
  - a buffered path for multi-cycle and load results.
- Keeps a per-register busy scoreboard so issue logic can detect pending long-latency writes.

Parameters:
- DEPTH, 4: entries in the multi-cycle result FIFO; power of 2, at least 2.
- STARVE_LIMIT, 3: number of consecutive cycles the ALU may win while the FIFO is non-empty before one ALU stall is forced; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  5  ALU destination.
- alu_data  in  32  ALU result.
- mem_valid  in  1  multi-cycle result present.
- mem_ready  out  1  FIFO can accept.
- mem_rd  in  5  multi-cycle destination.
- mem_data  in  32  multi-cycle result.
- issue_valid  in  1  long-latency op issued.
- issue_rd  in  5  its destination.
- busy  out  32  scoreboard; bit i set means a write to xi is pending.
- rd_addr  out  5  register file write address.
- reg_write  out  1  register file write enable.
- wr_data  out  32  register file write data.
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: every sequential element updates only on a rising clk edge, including reset. With rst high at an edge:
  - rd_addr, reg_write, wr_data, busy, fifo_count, FIFO pointers and starve_cnt all clear to 0;
  - in-flight FIFO entries are discarded;
  - rst overrides every simultaneous event.
- Output stage is registered. The source granted in cycle N appears on rd_addr/wr_data with reg_write=1 in cycle N+1. If nothing is granted, reg_write=0 in N+1 and rd_addr/wr_data hold their previous values.
- Handshakes:
  - mem beat accepted when mem_valid && mem_ready;
  - mem_ready = (fifo_count != DEPTH), registered-state based, so no same-cycle credit from a dequeue;
  - ALU beat accepted when alu_valid && alu_ready.
- Grant priority, evaluated each cycle:
  1. Starve stall: when starve_cnt == STARVE_LIMIT and the FIFO is non-empty, alu_ready=0 and the FIFO head is granted.
  2. Else, if alu_valid, the ALU is granted (alu_ready=1).
  3. Else, if the FIFO is non-empty, the FIFO head is granted.
  4. Else, no grant.
- alu_ready is 1 in every cycle except a starve stall.
- starve_cnt:
  - increments when the ALU is granted while the FIFO is non-empty;
  - clears on any FIFO grant, or whenever the FIFO is empty;
  - saturates at STARVE_LIMIT.
- FIFO:
  - enqueue and dequeue in the same cycle are allowed; fifo_count is unchanged;
  - pointers wrap modulo DEPTH;
  - a beat enqueued in cycle N is grantable no earlier than N+1, so baseline mem-to-reg_write latency is at least 2.
- x0 rule: a granted beat with rd=0 is consumed, but reg_write stays 0. issue_rd=0 never sets busy, and busy[0] is constantly 0.
- Scoreboard:
  - busy[issue_rd] sets at the edge where issue_valid=1;
  - busy[r] clears at the edge where a FIFO-sourced grant with rd=r is registered;
  - set and clear of the same r at the same edge: set wins;
  - re-issuing to an already-busy register leaves it at 1. Upstream guarantees at most one outstanding long-latency op per register.
  - ALU grants never modify busy.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty, no ALU grant occurs and mem_valid=1, the incoming mem beat is granted directly in the same cycle and is not enqueued. mem-to-reg_write latency becomes 1. Busy clears as for a FIFO grant.
- Undefined: every mem beat passes through the FIFO, with minimum latency 2.

Test Plan:
- Reset: hold rst 2 cycles with mem_valid=1 and issue_valid=1 -> reg_write=0, busy=0, fifo_count=0, alu_ready=1 after release.
- ALU write: alu_valid=1, rd=5, data=32'hDEAD_BEEF in cycle N -> cycle N+1 shows rd_addr=5, wr_data=32'hDEAD_BEEF, reg_write=1.
- x0 drop: ALU beat with rd=0, data=32'h1234 -> alu_ready=1, reg_write stays 0. issue_rd=0 -> busy[0]=0.
- Scoreboard: issue_valid with rd=7, then mem beat rd=7, data=32'hA5A5_A5A5 -> busy[7]=1 until the edge where reg_write=1 with rd_addr=7. Also drive issue rd=7 at the same edge as the clear -> busy[7] stays 1.
- FIFO full: DEPTH=4, alu_valid held 1, push 5 mem beats -> mem_ready=0 at fifo_count=4, fifth beat held. Starve stall after 3 ALU wins -> alu_ready=0 for exactly one cycle, head entry written in order.
- Bypass: WB_BYPASS_EN defined, FIFO empty, alu_valid=0, mem beat rd=3 in cycle N -> reg_write=1, rd_addr=3 in N+1. Undefined -> N+2.
